// File: rtl/aes_dec_key_schedule.sv
// AES-128 key schedule for a decryption engine: expands the cipher key once,
// then hands the round keys out from rk[10] down to rk[0] on request.
module aes_dec_key_schedule #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] cipher_key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         req_key,
  output logic [127:0] round_key,
  output logic         round_key_valid,
  output logic [3:0]   round_idx,
  output logic         last_key,
  output logic         busy
);

  localparam logic [3:0] LAST_IDX = 4'(NROUNDS);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e       state_q;
  logic [3:0]   count_q;
  logic [3:0]   ptr_q;
  logic [127:0] rk_q [0:NROUNDS];
  logic         key_ready_q;
  logic         round_key_valid_q;
  logic [127:0] round_key_q;
  logic [3:0]   round_idx_q;
  logic         last_key_q;
  logic         busy_q;

  logic [3:0]   prev_idx_d;
  logic [127:0] prev_key_d;
  logic [31:0]  rot_word_d;
  logic [31:0]  temp_d;
  logic [31:0]  w0_d, w1_d, w2_d, w3_d;
  logic [127:0] next_key_d;
  logic         accept_d;

  // One expansion step from the most recently written round key.
  always_comb begin
    prev_idx_d = count_q - 4'd1;
    prev_key_d = rk_q[prev_idx_d];
    rot_word_d = {prev_key_d[23:0], prev_key_d[31:24]};
    temp_d     = {sbox(rot_word_d[31:24]), sbox(rot_word_d[23:16]),
                  sbox(rot_word_d[15:8]),  sbox(rot_word_d[7:0])}
                 ^ {rcon(count_q), 24'h000000};
    w0_d       = prev_key_d[127:96] ^ temp_d;
    w1_d       = prev_key_d[95:64]  ^ w0_d;
    w2_d       = prev_key_d[63:32]  ^ w1_d;
    w3_d       = prev_key_d[31:0]   ^ w2_d;
    next_key_d = {w0_d, w1_d, w2_d, w3_d};
    accept_d   = key_valid & key_ready_q;
  end

  // Control FSM, key storage and registered presentation outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      count_q           <= 4'd0;
      ptr_q             <= 4'd0;
      for (int i = 0; i <= NROUNDS; i++) begin
        rk_q[i] <= 128'd0;
      end
      key_ready_q       <= 1'b1;
      round_key_valid_q <= 1'b0;
      round_key_q       <= 128'd0;
      round_idx_q       <= 4'd0;
      last_key_q        <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            rk_q[0]     <= cipher_key;
            count_q     <= 4'd1;
            state_q     <= EXPAND;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        EXPAND: begin
          rk_q[count_q] <= next_key_d;
          if (count_q == LAST_IDX) begin
            state_q           <= READY;
            ptr_q             <= LAST_IDX;
            key_ready_q       <= 1'b1;
            round_key_valid_q <= 1'b1;
            round_key_q       <= next_key_d;
            round_idx_q       <= LAST_IDX;
            last_key_q        <= 1'b0;
            busy_q            <= 1'b0;
          end else begin
            count_q <= count_q + 4'd1;
          end
        end
        READY: begin
          // A reload can only be accepted between blocks (ptr at the top).
          if (accept_d) begin
            rk_q[0]           <= cipher_key;
            count_q           <= 4'd1;
            state_q           <= EXPAND;
            key_ready_q       <= 1'b0;
            busy_q            <= 1'b1;
            round_key_valid_q <= 1'b0;
            round_key_q       <= 128'd0;
            round_idx_q       <= 4'd0;
            last_key_q        <= 1'b0;
          end else if (req_key) begin
            if (ptr_q == 4'd0) begin
              ptr_q       <= LAST_IDX;
              round_key_q <= rk_q[LAST_IDX];
              round_idx_q <= LAST_IDX;
              last_key_q  <= 1'b0;
              key_ready_q <= 1'b1;
            end else begin
              ptr_q       <= ptr_q - 4'd1;
              round_key_q <= rk_q[ptr_q - 4'd1];
              round_idx_q <= ptr_q - 4'd1;
              last_key_q  <= (ptr_q == 4'd1);
              key_ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign key_ready       = key_ready_q & ~reset;
  assign round_key       = round_key_q;
  assign round_key_valid = round_key_valid_q;
  assign round_idx       = round_idx_q;
  assign last_key        = last_key_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_aes_dec_key_schedule.sv
// Bench for aes_dec_key_schedule: FIPS-197 vector table, protocol corner cases and
// random keys checked against a GF(2^8)-derived S-box and word-level key expansion.
module tb_aes_dec_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] cipher_key;
  logic         key_valid;
  logic         key_ready;
  logic         req_key;
  logic [127:0] round_key;
  logic         round_key_valid;
  logic [3:0]   round_idx;
  logic         last_key;
  logic         busy;

  aes_dec_key_schedule #(.NROUNDS(10)) dut (
    .clk(clk), .reset(reset), .cipher_key(cipher_key), .key_valid(key_valid),
    .key_ready(key_ready), .req_key(req_key), .round_key(round_key),
    .round_key_valid(round_key_valid), .round_idx(round_idx),
    .last_key(last_key), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]   sb  [0:255];
  logic [127:0] mrk [0:10];

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // S-box as multiplicative inverse followed by the affine transform.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (b != 0 && gmul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input string tag, input int idx);
    chk({tag, " valid"}, 128'(round_key_valid), 128'd1);
    chk({tag, " idx"}, 128'(round_idx), 128'(idx));
    chk({tag, " key"}, round_key, mrk[idx]);
    chk({tag, " last"}, 128'(last_key), 128'(idx == 0));
    chk({tag, " key_ready"}, 128'(key_ready), 128'(idx == 10));
    chk({tag, " busy"}, 128'(busy), 128'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " valid"}, 128'(round_key_valid), 128'd0);
    chk({tag, " key"}, round_key, 128'd0);
    chk({tag, " idx"}, 128'(round_idx), 128'd0);
    chk({tag, " last"}, 128'(last_key), 128'd0);
    chk({tag, " busy"}, 128'(busy), 128'd0);
    chk({tag, " key_ready"}, 128'(key_ready), 128'd1);
  endtask

  // Called on the sample just after the accepting edge; counts edges until valid.
  task automatic wait_expand();
    int n = 1;
    int bsy = 0;
    int kr = 0;
    while (!round_key_valid && n < 30) begin
      bsy += int'(busy);
      kr  += int'(key_ready);
      tick();
      n++;
    end
    key_valid = 1'b0;
    chk("load latency", 128'(n), 128'd11);
    chk("busy cycles", 128'(bsy), 128'd10);
    chk("key_ready in expand", 128'(kr), 128'd0);
    check_ready("loaded", 10);
  endtask

  task automatic load(input logic [127:0] k, input logic hold_other);
    key_valid  = 1'b1;
    cipher_key = k;
    tick();
    model_expand(k);
    if (hold_other) cipher_key = ~k;
    else key_valid = 1'b0;
    wait_expand();
  endtask

  task automatic pulse(inout int cur);
    req_key = 1'b1;
    tick();
    req_key = 1'b0;
    cur = (cur == 0) ? 10 : cur - 1;
    check_ready("walk", cur);
  endtask

  task automatic random_walk();
    int cur = 10;
    for (int s = 0; s < 11; s++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_ready("hold", cur);
      end
      pulse(cur);
    end
    chk("random walk end", 128'(round_idx), 128'd10);
  endtask

  initial begin
    int cur;
    logic [127:0] cur_key;
    logic [127:0] k;
    reset = 1'b1; key_valid = 1'b0; req_key = 1'b0; cipher_key = 128'd0;
    build_sbox();
    tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    tbl[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    tbl[4] = '{128'h000102030405060708090a0b0c0d0e0f, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tbl[5] = '{128'h000102030405060708090a0b0c0d0e0f, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};

    #1;
    chk("key_ready during reset", 128'(key_ready), 128'd0);
    tick();
    reset = 1'b0;
    #1;
    check_idle("after reset");

    for (int p = 0; p < 3; p++) begin
      req_key = 1'b1;
      tick();
      req_key = 1'b0;
      check_idle("idle req");
    end

    cur_key = 128'd0;
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].key !== cur_key) begin
        load(tbl[v].key, 1'b0);
        cur_key = tbl[v].key;
      end
      cur = 10;
      while (cur != tbl[v].idx) pulse(cur);
      chk("table key", round_key, tbl[v].exp);
      chk("table idx", 128'(round_idx), 128'(tbl[v].idx));
      for (int s = 0; s <= tbl[v].idx; s++) pulse(cur);
      chk("table wrap idx", 128'(round_idx), 128'd10);
    end

    // Back-pressure: key_valid held through EXPAND and again at ptr 5.
    load(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    chk("bp rk10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    cur = 10;
    for (int s = 0; s < 5; s++) pulse(cur);
    key_valid  = 1'b1;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    for (int s = 0; s < 3; s++) begin
      tick();
      check_ready("bp ptr5", 5);
    end
    key_valid = 1'b0;
    for (int s = 0; s < 6; s++) pulse(cur);

    // key_valid and req_key together at ptr 10: reload wins.
    key_valid  = 1'b1;
    req_key    = 1'b1;
    cipher_key = 128'h000102030405060708090a0b0c0d0e0f;
    tick();
    req_key = 1'b0;
    key_valid = 1'b0;
    model_expand(cipher_key);
    chk("simul valid drop", 128'(round_key_valid), 128'd0);
    chk("simul key zero", round_key, 128'd0);
    chk("simul busy", 128'(busy), 128'd1);
    wait_expand();
    chk("simul rk10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset on the 5th EXPAND cycle.
    cur = 10;
    for (int s = 0; s < 11; s++) pulse(cur);
    key_valid  = 1'b1;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    key_valid = 1'b0;
    for (int s = 0; s < 4; s++) tick();
    chk("busy before reset", 128'(busy), 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_idle("mid reset");
    k = {$urandom, $urandom, $urandom, $urandom};
    load(k, 1'b0);
    random_walk();

    for (int r = 0; r < 4; r++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load(k, 1'b0);
      random_walk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
